// File: rtl/memory_stage_pkg.sv
// Shared constants, types and the memory-operation priority decode for the MEM stage.
package memory_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 11;
    localparam logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}};

    typedef logic [2:0] reg_idx_t;

    typedef enum logic [2:0] {
        MEM_NONE,
        MEM_LOAD,
        MEM_STORE,
        MEM_PUSH,
        MEM_POP
    } mem_op_e;

    // Simultaneous push and pop decodes to MEM_NONE; the stage flags it as a stack fault.
    function automatic mem_op_e decode_mem_op(input logic push, input logic pop,
                                              input logic wr, input logic rd);
        if (push && pop) return MEM_NONE;
        if (push)        return MEM_PUSH;
        if (pop)         return MEM_POP;
        if (wr)          return MEM_STORE;
        if (rd)          return MEM_LOAD;
        return MEM_NONE;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// EX -> MEM/WB bundle: stage control and operands in, MEM/WB register and stack status out.
interface memory_stage_if;
    import memory_stage_pkg::*;

    logic              stall;
    logic              flush;
    logic              mem_read;
    logic              mem_write;
    logic              push;
    logic              pop;
    logic              wb_en_in;
    logic              wb_sel_in;
    reg_idx_t          rdst_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [DATA_W-1:0] immediate_in;
    logic [DATA_W-1:0] store_data_in;

    logic [DATA_W-1:0] alu_value;
    logic [DATA_W-1:0] immediate_value;
    logic              wb_sel;
    logic              wb_en;
    reg_idx_t          rdst;
    logic              valid;
    logic [ADDR_W-1:0] sp;
    logic              stack_fault;

    modport master (
        output stall, flush, mem_read, mem_write, push, pop, wb_en_in, wb_sel_in, rdst_in,
               alu_result_in, immediate_in, store_data_in,
        input  alu_value, immediate_value, wb_sel, wb_en, rdst, valid, sp, stack_fault
    );

    modport slave (
        input  stall, flush, mem_read, mem_write, push, pop, wb_en_in, wb_sel_in, rdst_in,
               alu_result_in, immediate_in, store_data_in,
        output alu_value, immediate_value, wb_sel, wb_en, rdst, valid, sp, stack_fault
    );

endinterface

// File: rtl/memory_stage_data_memory.sv
// Single-port data memory: combinational read, synchronous write, contents never reset.
module data_memory
    import memory_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-memory load/store, stack push/pop with stack pointer, and the MEM/WB register.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    memory_stage_if.slave bus
);

    logic [DATA_W-1:0] alu_value_q, alu_value_d;
    logic [DATA_W-1:0] immediate_value_q, immediate_value_d;
    logic              wb_sel_q, wb_sel_d;
    logic              wb_en_q, wb_en_d;
    logic              valid_q, valid_d;
    logic              stack_fault_q, stack_fault_d;
    reg_idx_t          rdst_q, rdst_d;
    logic [ADDR_W-1:0] sp_q, sp_d;

    logic [ADDR_W-1:0] addr_in, mem_addr;
    logic [DATA_W-1:0] rdata;
    mem_op_e           op;
    logic              advance, sp_full, sp_empty, stack_conflict, mem_we;

    assign op             = decode_mem_op(bus.push, bus.pop, bus.mem_write, bus.mem_read);
    assign stack_conflict = bus.push & bus.pop;
    assign addr_in        = bus.alu_result_in[ADDR_W-1:0];
    assign sp_full        = (sp_q == '0);
    assign sp_empty       = (sp_q == SP_INIT);
    // rst gating keeps a write that is in flight at reset assertion from landing.
    assign advance        = ~bus.flush & ~bus.stall & ~rst;
    assign mem_we         = advance & ((op == MEM_STORE) | ((op == MEM_PUSH) & ~sp_full));

    always_comb begin
        case (op)
            MEM_PUSH: mem_addr = sp_q;
            MEM_POP:  mem_addr = sp_q + ADDR_W'(1);
            default:  mem_addr = addr_in;
        endcase
    end

    data_memory u_data_memory (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (bus.store_data_in),
        .rdata_o (rdata)
    );

    always_comb begin
        alu_value_d       = alu_value_q;
        immediate_value_d = immediate_value_q;
        wb_sel_d          = wb_sel_q;
        wb_en_d           = wb_en_q;
        rdst_d            = rdst_q;
        valid_d           = valid_q;
        sp_d              = sp_q;
        stack_fault_d     = 1'b0;

        if (bus.flush) begin
            alu_value_d       = '0;
            immediate_value_d = '0;
            wb_sel_d          = 1'b0;
            wb_en_d           = 1'b0;
            rdst_d            = '0;
            valid_d           = 1'b0;
        end else if (!bus.stall) begin
            immediate_value_d = bus.immediate_in;
            wb_sel_d          = bus.wb_sel_in;
            wb_en_d           = bus.wb_en_in;
            rdst_d            = bus.rdst_in;
            valid_d           = 1'b1;
            alu_value_d       = bus.alu_result_in;
            if (stack_conflict) begin
                stack_fault_d = 1'b1;
                alu_value_d   = '0;
            end
            case (op)
                MEM_LOAD: alu_value_d = rdata;
                MEM_PUSH: begin
                    if (sp_full) stack_fault_d = 1'b1;
                    else         sp_d          = sp_q - ADDR_W'(1);
                end
                MEM_POP: begin
                    if (sp_empty) begin
                        stack_fault_d = 1'b1;
                        alu_value_d   = '0;
                    end else begin
                        alu_value_d = rdata;
                        sp_d        = sp_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_value_q       <= '0;
            immediate_value_q <= '0;
            wb_sel_q          <= 1'b0;
            wb_en_q           <= 1'b0;
            rdst_q            <= '0;
            valid_q           <= 1'b0;
            sp_q              <= SP_INIT;
            stack_fault_q     <= 1'b0;
        end else begin
            alu_value_q       <= alu_value_d;
            immediate_value_q <= immediate_value_d;
            wb_sel_q          <= wb_sel_d;
            wb_en_q           <= wb_en_d;
            rdst_q            <= rdst_d;
            valid_q           <= valid_d;
            sp_q              <= sp_d;
            stack_fault_q     <= stack_fault_d;
        end
    end

    assign bus.alu_value       = alu_value_q;
    assign bus.immediate_value = immediate_value_q;
    assign bus.wb_sel          = wb_sel_q;
    assign bus.wb_en           = wb_en_q;
    assign bus.rdst            = rdst_q;
    assign bus.valid           = valid_q;
    assign bus.sp              = sp_q;
    assign bus.stack_fault     = stack_fault_q;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage plus MEM/WB pipeline register, directly upstream of the write-back stage.
- Performs data-memory load/store and stack push/pop, and owns the stack pointer.
- Registers the alu value, immediate value, select and destination for write-back one cycle later.
- Outputs alu_value, immediate_value and wb_sel connect straight to the write-back stage inputs alu_value, immediate_value and sel.

Parameters:
DATA_W, 16, datapath width
ADDR_W, 11, data-memory address width (depth 2**ADDR_W words)
SP_INIT, 2**ADDR_W-1, stack-pointer reset value (stack grows down)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  hold stage; no state change
flush  in  1  synchronous bubble insert
mem_read  in  1  load: mem[alu_result_in[ADDR_W-1:0]]
mem_write  in  1  store store_data_in to mem[alu_result_in[ADDR_W-1:0]]
push  in  1  stack push of store_data_in
pop  in  1  stack pop into alu_value
wb_en_in  in  1  register write enable from EX
wb_sel_in  in  1  0 = alu/mem result, 1 = immediate
rdst_in  in  3  destination register
alu_result_in  in  DATA_W  ALU result / memory address
immediate_in  in  DATA_W  immediate operand
store_data_in  in  DATA_W  store/push data
alu_value  out  DATA_W  registered ALU or memory data
immediate_value  out  DATA_W  registered immediate
wb_sel  out  1  registered select
wb_en  out  1  registered write enable
rdst  out  3  registered destination
valid  out  1  MEM/WB slot holds a real instruction
sp  out  ADDR_W  current stack pointer
stack_fault  out  1  one-cycle pulse on illegal stack access

Behaviour:
- Reset (async, any time, including mid-operation): all outputs 0 except sp = SP_INIT. Memory contents are not cleared. An in-flight write at reset assertion is dropped.
- Latency: one clock from inputs to MEM/WB outputs. Memory read is combinational from the array and captured into alu_value at the same edge.
- Operation priority (at most one per cycle): push/pop > mem_write > mem_read > passthrough.
- Passthrough: alu_value <= alu_result_in.
- mem_read: alu_value <= mem[addr].
- mem_write: mem[addr] <= store_data_in; alu_value <= alu_result_in.
- push: mem[sp] <= store_data_in, then sp <= sp-1.
- pop: alu_value <= mem[sp+1], then sp <= sp+1.
- Address uses the low ADDR_W bits of alu_result_in; upper bits are ignored (wrap).
- Overflow (push with sp == 0): no write, sp unchanged, stack_fault = 1 for one cycle, pipeline proceeds.
- Underflow (pop with sp == SP_INIT): sp unchanged, alu_value <= 0, stack_fault = 1.
- push and pop together: neither executes, stack_fault = 1, alu_value <= 0.
- immediate_value, wb_sel, wb_en, rdst always copy their *_in inputs. valid <= 1 on every non-stalled, non-flushed edge.
- stall = 1: all registers and sp hold, no memory write, stack_fault <= 0.
- flush = 1: no memory write, sp unchanged. Outputs become a bubble: wb_en = 0, valid = 0, data outputs 0, stack_fault = 0.
- flush overrides stall.
- Store followed by load to the same address in the next cycle returns the new data.

Decomposition:
- Shared package holds: DATA_W, ADDR_W, SP_INIT constants; the register-index typedef (3 bits); and a mem-op enum {MEM_NONE, MEM_LOAD, MEM_STORE, MEM_PUSH, MEM_POP} produced by a priority decode.
- One sub-module, data_memory: single-port array with async read and sync write, no reset.
- Stack pointer and the MEM/WB register stay in memory_stage.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, sp = 2047. Release, passthrough alu_result_in = 120, immediate_in = 150, wb_sel_in = 1 -> next edge alu_value = 120, immediate_value = 150, wb_sel = 1, valid = 1.
- Store/load: mem_write addr 5 data 0xBEEF, then mem_read addr 5 -> alu_value = 0xBEEF. Addr 0x0805 also reads 0xBEEF (wrap).
- Stack: push 0x1111, push 0x2222 -> sp = 2045. Pop -> 0x2222, pop -> 0x1111, sp = 2047. Another pop -> stack_fault pulse, alu_value = 0, sp = 2047.
- Overflow: force sp to 0 via 2047 pushes, push again -> stack_fault = 1, sp = 0, mem[0] unchanged.
- Stall: stall = 1 with mem_write addr 7 data 0x0A0A -> outputs hold, mem[7] unchanged. Release -> write happens.
- Flush: flush = 1 together with stall = 1 and push -> wb_en = 0, valid = 0, sp unchanged. push + pop together -> stack_fault = 1, no sp change.
